// File: rtl/imm_branch_pkg.sv
// imm_branch_pkg: shared types and constants for the immediate / branch-target
// generator.
//   mode_t  - request mode encoding (SEXT, ZEXT, UPPER, BRANCH)
//   PC_STEP - distance from the current instruction to the next one
package imm_branch_pkg;

   typedef enum logic [1:0] {
      MODE_SEXT   = 2'b00,
      MODE_ZEXT   = 2'b01,
      MODE_UPPER  = 2'b10,
      MODE_BRANCH = 2'b11
   } mode_t;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: combinational extend/place of a raw immediate.
//   i_mode - request mode
//   i_imm  - raw immediate, IN_W bits
//   o_ext  - extended or placed value, OUT_W bits
// BRANCH produces the sign-extended immediate; shifting and the pc add happen
// downstream.
module imm_ext_stage
   import imm_branch_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  mode_t              i_mode,
   input  logic [IN_W-1:0]    i_imm,
   output logic [OUT_W-1:0]   o_ext
);

   always_comb begin
      o_ext = '0;
      case (i_mode)
         MODE_SEXT:   o_ext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
         MODE_ZEXT:   o_ext = {{(OUT_W-IN_W){1'b0}}, i_imm};
         MODE_UPPER:  o_ext = {i_imm, {(OUT_W-IN_W){1'b0}}};
         MODE_BRANCH: o_ext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
         default:     o_ext = '0;
      endcase
   end

endmodule

// File: rtl/imm_branch_gen.sv
// imm_branch_gen: two-stage valid/ready pipeline producing extended immediates
// and branch targets.
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - request handshake
//   in_mode, in_imm, in_pc- request fields
//   out_valid/out_ready   - result handshake
//   out_data              - result
//   out_ovf               - branch-target wrap flag (only with IMM_BRANCH_OVF_EN)
// S1 holds the extended value, mode and pc; S2 holds the final result.
// Optional feature macro: IMM_BRANCH_OVF_EN.
module imm_branch_gen
   import imm_branch_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [IN_W-1:0]   in_imm,
   input  logic [OUT_W-1:0]  in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data
`ifdef IMM_BRANCH_OVF_EN
   ,
   output logic              out_ovf
`endif
);

   logic              r_s1_valid;
   logic [OUT_W-1:0]  r_s1_ext;
   mode_t             r_s1_mode;
   logic [OUT_W-1:0]  r_s1_pc;

   logic              r_s2_valid;
   logic [OUT_W-1:0]  r_s2_data;

   logic [OUT_W-1:0]  w_ext;
   logic [OUT_W-1:0]  w_result;
   logic              w_s2_ready;
   logic              w_s1_adv;

   imm_ext_stage #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_ext (
      .i_mode (mode_t'(in_mode)),
      .i_imm  (in_imm),
      .o_ext  (w_ext)
   );

   assign w_s2_ready = !r_s2_valid || out_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_ready;
   assign in_ready   = !r_s1_valid || w_s1_adv;

`ifdef IMM_BRANCH_OVF_EN
   // Four guard bits hold the full signed sum: |offset| <= 2^(OUT_W+2) and
   // pc < 2^OUT_W. Any nonzero guard bit means the target left [0, 2^OUT_W).
   localparam int WW = OUT_W + 4;
   logic [WW-1:0] w_sum_wide;
   logic          w_ovf;
   logic          r_s2_ovf;

   assign w_sum_wide = {4'b0000, r_s1_pc} + WW'(PC_STEP)
                     + ({{4{r_s1_ext[OUT_W-1]}}, r_s1_ext} << SHAMT);
   assign w_ovf      = (r_s1_mode == MODE_BRANCH) && (|w_sum_wide[WW-1:OUT_W]);
   assign w_result   = (r_s1_mode == MODE_BRANCH) ? w_sum_wide[OUT_W-1:0] : r_s1_ext;
   assign out_ovf    = r_s2_ovf;
`else
   logic [OUT_W-1:0] w_branch;

   // Shifted-out high bits of the offset and the carry are simply discarded.
   assign w_branch = r_s1_pc + OUT_W'(PC_STEP) + (r_s1_ext << SHAMT);
   assign w_result = (r_s1_mode == MODE_BRANCH) ? w_branch : r_s1_ext;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_ext   <= '0;
         r_s1_mode  <= MODE_SEXT;
         r_s1_pc    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
`ifdef IMM_BRANCH_OVF_EN
         r_s2_ovf   <= 1'b0;
`endif
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_ext  <= w_ext;
               r_s1_mode <= mode_t'(in_mode);
               r_s1_pc   <= in_pc;
            end
         end
         // S2 data only changes when it loads a new result, so it holds
         // steady while stalled.
         if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= w_result;
`ifdef IMM_BRANCH_OVF_EN
               r_s2_ovf  <= w_ovf;
`endif
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;

endmodule

// File: doc/imm_branch_gen.md
IMM_BRANCH_GEN -- requirements
Module: imm_branch_gen

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 The block SHALL have parameter OUT_W, default 32, result width; OUT_W > IN_W is required.
REQ-003 The block SHALL have parameter SHAMT, default 2, left-shift applied in branch mode; legal range 0..3.
REQ-004 The block SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, request present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, request accepted when in_valid && in_ready.
REQ-008 The block SHALL have port in_mode, input, 2 bits: 00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH.
REQ-009 The block SHALL have port in_imm, input, IN_W bits, raw immediate.
REQ-010 The block SHALL have port in_pc, input, OUT_W bits, address of the current instruction.
REQ-011 The block SHALL have port out_valid, output, 1 bit, result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, consumer accepts when out_valid && out_ready.
REQ-013 The block SHALL have port out_data, output, OUT_W bits, result.
REQ-014 The block SHALL have port out_ovf, output, 1 bit, branch-target wrap flag; present only under IMM_BRANCH_OVF_EN.

Function
REQ-015 SEXT SHALL produce in_imm sign-extended from bit IN_W-1 to OUT_W.
REQ-016 ZEXT SHALL produce in_imm zero-extended to OUT_W.
REQ-017 UPPER SHALL produce in_imm placed in bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-018 BRANCH SHALL produce (in_pc + 4 + (SEXT(in_imm) << SHAMT)) mod 2^OUT_W; shifted-out high bits are discarded.
REQ-019 The pipeline SHALL have two register stages: S1 holds the extended value, mode and pc; S2 holds the shifted and added result.
REQ-020 Latency SHALL be exactly 2 cycles from accept to out_valid when out_ready is held 1.
REQ-021 Throughput SHALL be one result per cycle with out_ready held 1.
REQ-022 S2 SHALL load when S2 is empty or drains in the same cycle; S1 SHALL load under the same rule against S1.
REQ-023 in_ready SHALL equal !S1.valid || S1 advances, combinationally, with no dependence on in_valid.
REQ-024 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 Accept, S1->S2 transfer and output drain in the same cycle SHALL lose or duplicate no result.
REQ-026 Results SHALL leave the block in acceptance order.

Reset
REQ-027 While rst=1 at a clock edge, S1.valid, S2.valid, out_valid, out_data and out_ovf SHALL clear to 0.
REQ-028 Reset mid-operation SHALL discard in-flight results without emitting them.
REQ-029 in_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With IMM_BRANCH_OVF_EN defined, out_ovf SHALL be 1 iff the mode is BRANCH and the true signed-offset sum leaves [0, 2^OUT_W).
REQ-031 out_ovf SHALL be registered alongside out_data, and SHALL be 0 for all other modes.
REQ-032 Without IMM_BRANCH_OVF_EN, port out_ovf and its logic SHALL be absent, and out_data SHALL be unchanged.

Structure
REQ-033 Package imm_branch_pkg SHALL hold the mode enum (MODE_SEXT, MODE_ZEXT, MODE_UPPER, MODE_BRANCH) and constant PC_STEP = 4.
REQ-034 Sub-module imm_ext_stage SHALL implement the combinational S1 extend/place function, parametrised by IN_W and OUT_W.
REQ-035 Shift and add SHALL reside in the top module's S2 logic.

Verification
REQ-036 Sequence: reset, then SEXT imm=16'h8004 with out_ready=1 -> out_data=32'hFFFF8004 exactly 2 cycles after accept.
REQ-037 Sequence: ZEXT imm=16'h8004 -> 32'h00008004; UPPER imm=16'h1234 -> 32'h12340000.
REQ-038 BRANCH pc=32'h00400000, imm=16'hFFFF, SHAMT=2 -> 32'h00400000, out_ovf=0; pc=32'hFFFFFFFC, imm=16'h0001 -> 32'h00000004, out_ovf=1.
REQ-039 Back-to-back stream of 10 requests with out_ready toggled every cycle -> 10 results in order, none duplicated, out_data stable while stalled.
REQ-040 out_ready=0 with 3 requests offered -> in_ready drops after 2 accepts; releasing out_ready drains both, then accepts the third.
REQ-041 rst pulsed while S1 and S2 are both full -> no out_valid the next cycle, in_ready=1.
